// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register data width, HI/LO op encodings and
// the multiply/divide unit's control states.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_DIVU  = 2'd1,
    OP_MTHI  = 2'd2,
    OP_MTLO  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_e;

endpackage

// File: rtl/mult_div_datapath.sv
// Iteration datapath for mult_div_unit: shift-add multiply and, when
// MULT_DIV_DIVIDE_EN is defined, restoring divide on one shared adder.
module mult_div_datapath
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
`ifdef MULT_DIV_DIVIDE_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  localparam int unsigned ACC_W = 2 * WIDTH;
`ifdef MULT_DIV_DIVIDE_EN
  localparam int unsigned SUM_W = WIDTH + 2;
`else
  localparam int unsigned SUM_W = WIDTH + 1;
`endif

  // Multiply: acc is P. Divide: acc is {remainder, dividend/quotient}.
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [WIDTH-1:0] rt_q;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [SUM_W-1:0] sum;
`ifdef MULT_DIV_DIVIDE_EN
  logic             div_q;
  logic             add_cin;
  logic [WIDTH:0]   shifted;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      rt_q  <= '0;
`ifdef MULT_DIV_DIVIDE_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
      acc   <= {WIDTH'(0), rs};
      rt_q  <= rt;
`ifdef MULT_DIV_DIVIDE_EN
      div_q <= div;
`endif
    end else if (step) begin
      acc   <= acc_next;
    end
  end

  always_comb begin
    addend = acc[0] ? rt_q : '0;
    add_a  = {1'b0, acc[ACC_W-1:WIDTH]};
    add_b  = {1'b0, addend};
`ifdef MULT_DIV_DIVIDE_EN
    shifted = acc[ACC_W-1:WIDTH-1];
    add_cin = 1'b0;
    // Divide reuses the adder as a trial subtractor; carry-out means no borrow.
    if (div_q) begin
      add_a   = shifted;
      add_b   = ~{1'b0, rt_q};
      add_cin = 1'b1;
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + SUM_W'(add_cin);
`else
    sum = add_a + add_b;
`endif
    acc_next = {sum[WIDTH:0], acc[WIDTH-1:1]};
`ifdef MULT_DIV_DIVIDE_EN
    if (div_q) begin
      acc_next = sum[WIDTH+1] ? {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
  end

  assign hi_c = acc_next[ACC_W-1:WIDTH];
  assign lo_c = acc_next[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULTU/DIVU unit with architectural HI/LO and a START/BUSY/DONE
// handshake. DIVU support is built only when MULT_DIV_DIVIDE_EN is defined.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned  CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_e        state;
  md_state_e        state_next;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_cnt_next;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero_next;
  logic             dp_load;
  logic             dp_step;
`ifdef MULT_DIV_DIVIDE_EN
  logic             dp_div;
`endif

  mult_div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (dp_load),
    .step    (dp_step),
`ifdef MULT_DIV_DIVIDE_EN
    .div     (dp_div),
`endif
    .rs      (rs),
    .rt      (rt),
    .hi_c    (res_hi),
    .lo_c    (res_lo)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      step_cnt <= step_cnt_next;
      hi       <= hi_next;
      lo       <= lo_next;
      div_zero <= div_zero_next;
      busy     <= (state_next == ST_MUL) || (state_next == ST_DIV);
      done     <= (state_next == ST_FIN);
    end
  end

  always_comb begin
    state_next    = state;
    step_cnt_next = step_cnt;
    hi_next       = hi;
    lo_next       = lo;
    div_zero_next = div_zero;
    dp_load       = 1'b0;
    dp_step       = 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
    dp_div        = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_FIN: begin
        state_next = ST_IDLE;
        if (start) begin
          state_next    = ST_FIN;
          step_cnt_next = '0;
          div_zero_next = 1'b0;
          case (op_e'(op))
            OP_MULTU: begin
              state_next = ST_MUL;
              dp_load    = 1'b1;
            end
            OP_DIVU: begin
`ifdef MULT_DIV_DIVIDE_EN
              if (rt == '0) begin
                hi_next       = rs;
                lo_next       = '1;
                div_zero_next = 1'b1;
              end else begin
                state_next = ST_DIV;
                dp_load    = 1'b1;
                dp_div     = 1'b1;
              end
`endif
            end
            OP_MTHI: hi_next = rs;
            OP_MTLO: lo_next = rs;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        dp_step = 1'b1;
        // HI/LO take the combinational result of the final step on the completing edge.
        if (step_cnt == LAST_STEP) begin
          step_cnt_next = '0;
          hi_next       = res_hi;
          lo_next       = res_lo;
          state_next    = ST_FIN;
        end else begin
          step_cnt_next = step_cnt + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case
// sequences and random ops against an arithmetic reference model.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int unsigned W = DATA_WIDTH;
`ifdef MULT_DIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0] op;
    logic [7:0] rs;
    logic [7:0] rt;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dz;
    int         busy_cycles;
    string      name;
  } vec_t;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] rs;
  logic [7:0] rt;
  logic       busy;
  logic       done;
  logic [7:0] hi;
  logic [7:0] lo;
  logic       div_zero;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_hi = 8'h00;
  logic [7:0] m_lo = 8'h00;
  logic       m_dz = 1'b0;

  vec_t vecs [10];

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each op.
  task automatic model_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          output vec_t v);
    logic [15:0] p;
    v.op = o; v.rs = a; v.rt = b;
    v.hi = m_hi; v.lo = m_lo; v.dz = 1'b0; v.busy_cycles = 0; v.name = "rand";
    case (o)
      2'd0: begin
        p = 16'(a) * 16'(b);
        v.hi = p[15:8]; v.lo = p[7:0]; v.busy_cycles = W;
      end
      2'd1: begin
        if (DIV_EN) begin
          if (b == 8'd0) begin
            v.hi = a; v.lo = 8'hFF; v.dz = 1'b1;
          end else begin
            v.hi = a % b; v.lo = a / b; v.busy_cycles = W;
          end
        end
      end
      2'd2: v.hi = a;
      default: v.lo = a;
    endcase
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input vec_t v, input bit pulse);
    int n;
    start = 1'b1; op = v.op; rs = v.rs; rt = v.rt;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n = 0;
    if (v.busy_cycles > 0) begin
      chk({v.name, " hold_hi"}, 16'(hi), 16'(m_hi));
      chk({v.name, " hold_lo"}, 16'(lo), 16'(m_lo));
    end
    while (busy && n < 40) begin
      if (pulse && n == 1) begin
        start = 1'b1; op = OP_MTHI; rs = 8'h5A;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clock);
    end
    start = 1'b0;
    chk({v.name, " busy_cycles"}, 16'(n), 16'(v.busy_cycles));
    chk({v.name, " done"}, 16'(done), 16'(1));
    chk({v.name, " hi"}, 16'(hi), 16'(v.hi));
    chk({v.name, " lo"}, 16'(lo), 16'(v.lo));
    chk({v.name, " div_zero"}, 16'(div_zero), 16'(v.dz));
    m_hi = v.hi; m_lo = v.lo; m_dz = v.dz;
  endtask

  task automatic finish_op(input string nm);
    @(negedge clock);
    chk({nm, " done_one_cycle"}, 16'(done), 16'(0));
    chk({nm, " idle_busy"}, 16'(busy), 16'(0));
    chk({nm, " idle_hi"}, 16'(hi), 16'(m_hi));
    chk({nm, " idle_lo"}, 16'(lo), 16'(m_lo));
    chk({nm, " idle_div_zero"}, 16'(div_zero), 16'(m_dz));
  endtask

  initial begin
    vec_t v;
    int   dn;
    logic [1:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{OP_MULTU, 8'd200, 8'd150, 8'h75, 8'h30, 1'b0, 8, "multu_200_150"};
    vecs[1] = '{OP_DIVU, 8'd200, 8'd7, DIV_EN ? 8'h04 : 8'h75, DIV_EN ? 8'h1C : 8'h30,
                1'b0, DIV_EN ? 8 : 0, "divu_200_7"};
    vecs[2] = '{OP_DIVU, 8'h55, 8'h00, DIV_EN ? 8'h55 : 8'h75, DIV_EN ? 8'hFF : 8'h30,
                DIV_EN, 0, "divu_by_zero"};
    vecs[3] = '{OP_MTLO, 8'h3C, 8'h11, DIV_EN ? 8'h55 : 8'h75, 8'h3C, 1'b0, 0, "mtlo"};
    vecs[4] = '{OP_MTHI, 8'h99, 8'h22, 8'h99, 8'h3C, 1'b0, 0, "mthi"};
    vecs[5] = '{OP_MULTU, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8, "multu_zero"};
    vecs[6] = '{OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 8, "multu_max"};
    vecs[7] = '{OP_MULTU, 8'h01, 8'h80, 8'h00, 8'h80, 1'b0, 8, "multu_1_80"};
    vecs[8] = '{OP_DIVU, 8'hFF, 8'h01, 8'h00, DIV_EN ? 8'hFF : 8'h80,
                1'b0, DIV_EN ? 8 : 0, "divu_ff_1"};
    vecs[9] = '{OP_DIVU, 8'h03, 8'd200, DIV_EN ? 8'h03 : 8'h00, DIV_EN ? 8'h00 : 8'h80,
                1'b0, DIV_EN ? 8 : 0, "divu_small"};

    reset_n = 1'b0; start = 1'b0; op = 2'd0; rs = 8'h00; rt = 8'h00;
    @(negedge clock);
    @(negedge clock);
    chk("reset hi", 16'(hi), 16'(0));
    chk("reset lo", 16'(lo), 16'(0));
    chk("reset busy", 16'(busy), 16'(0));
    chk("reset done", 16'(done), 16'(0));
    chk("reset div_zero", 16'(div_zero), 16'(0));
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], 1'b0);
      finish_op(vecs[i].name);
    end

    // START during BUSY is dropped; a new START in the FIN cycle is taken.
    v = '{OP_MULTU, 8'd15, 8'd15, 8'h00, 8'hE1, 1'b0, 8, "multu_15_pulse"};
    run_op(v, 1'b1);
    v = '{OP_MTHI, 8'hA5, 8'h00, 8'hA5, 8'hE1, 1'b0, 0, "mthi_in_fin"};
    run_op(v, 1'b0);
    finish_op("mthi_in_fin");

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      model_op(ro, ra, rb, v);
      run_op(v, 1'b0);
      if ($urandom_range(0, 2) != 0) finish_op("rand");
    end
    finish_op("rand_tail");

    // Asynchronous reset on the 4th BUSY cycle aborts the multiply.
    start = 1'b1; op = OP_MULTU; rs = 8'hFF; rt = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort busy4", 16'(busy), 16'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("abort hi", 16'(hi), 16'(0));
    chk("abort lo", 16'(lo), 16'(0));
    chk("abort busy", 16'(busy), 16'(0));
    chk("abort done", 16'(done), 16'(0));
    chk("abort div_zero", 16'(div_zero), 16'(0));
    @(negedge clock);
    reset_n = 1'b1;
    m_hi = 8'h00; m_lo = 8'h00; m_dz = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) dn++;
    end
    chk("abort no_done", 16'(dn), 16'(0));
    chk("abort idle_busy", 16'(busy), 16'(0));
    v = '{OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 8, "multu_after_abort"};
    run_op(v, 1'b0);
    finish_op("multu_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative unsigned multiply/divide unit with architectural HI/LO registers for the MIPS CPU. Sits directly downstream of the register file: takes the two read ports (RD1 → RS, RD2 → RT) as operands, computes MULTU/DIVU over several cycles, and holds the results in HI/LO for later MFHI/MFLO reads. A simple START/BUSY/DONE handshake lets the control unit stall while the unit is busy.

## Interface
- WIDTH, 8: operand and HI/LO width; matches register file data width.
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only when BUSY=0.
- OP  in  2  0=MULTU, 1=DIVU, 2=MTHI, 3=MTLO.
- RS  in  WIDTH  first operand (multiplicand/dividend/MT source).
- RT  in  WIDTH  second operand (multiplier/divisor).
- BUSY  out  1  high while a MULTU/DIVU iterates.
- DONE  out  1  one-cycle completion pulse.
- HI  out  WIDTH  HI register (product upper half / remainder).
- LO  out  WIDTH  LO register (product lower half / quotient).
- DIV_ZERO  out  1  last completed DIVU had RT=0.

## Operation
- States: IDLE, MUL, DIV, FIN. BUSY=1 in MUL/DIV; DONE=1 in FIN only.
- Acceptance: START=1 in IDLE or FIN → RS/RT/OP latched; DIV_ZERO cleared. START in MUL/DIV ignored, no queuing.
- MULTU: shift-add; accumulator P is 2·WIDTH bits, initialised {0, RS}; each step: if P[0], add RT into upper WIDTH+1 bits (keep carry), then shift P right by 1. After WIDTH steps {HI,LO}=RS·RT (exact, no overflow).
- DIVU: restoring; remainder WIDTH+1 bits; each step shifts in next dividend bit MSB-first, trial-subtracts RT, keeps result and sets quotient bit if non-negative. After WIDTH steps LO=quotient, HI=remainder.
- DIVU with RT=0: no iteration; IDLE/FIN → FIN directly; HI=RS, LO=all ones, DIV_ZERO=1.
- MTHI/MTLO: HI (or LO) ← RS on accepting edge; → FIN; other register unchanged.
- HI/LO hold previous values throughout MUL/DIV; written only on the completing edge. Iteration uses internal registers.
- FIN lasts exactly one cycle, then → IDLE unless a new START is accepted (back-to-back allowed).
- DIV_ZERO holds until next accepted START.

## Timing
- Reset (async, any state): IDLE; HI=LO=0; BUSY=DONE=DIV_ZERO=0; step counter 0. Reset mid-operation aborts; no DONE.
- Accepting edge E0: MULTU/DIVU → BUSY=1 from E0 through edge E(WIDTH); HI/LO written at E(WIDTH); DONE=1 between E(WIDTH) and E(WIDTH+1). BUSY high exactly WIDTH cycles.
- MTHI/MTLO and divide-by-zero: BUSY never asserts; result visible and DONE=1 in cycle after E0.
- DONE and new HI/LO are visible in the same cycle.
- Step counter: $clog2(WIDTH)+1 bits, counts 0..WIDTH-1, no wrap beyond.

## Configuration
- MULT_DIV_DIVIDE_EN defined: DIVU fully supported as above (DIV state, restoring datapath, DIV_ZERO).
- Not defined: divider logic and DIV state removed; OP=1 behaves as a no-op: → FIN next cycle, HI/LO unchanged, DIV_ZERO tied 0.

## Structure
- Shared package mips_pkg: OP encodings (OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO), FSM state enum, default data width constant shared with the register file.
- One sub-module: mult_div_datapath (accumulator/remainder registers, WIDTH+1-bit adder/subtractor, step logic); FSM, counter and HI/LO in mult_div_unit.

## Test plan
- Reset: RESET_N=0 mid-run → HI=LO=0, BUSY=DONE=DIV_ZERO=0 immediately, before the next edge.
- MULTU RS=200, RT=150 → BUSY 8 cycles, DONE 1 cycle, HI=0x75, LO=0x30 (30000).
- DIVU RS=200, RT=7 → BUSY 8 cycles, LO=0x1C, HI=0x04, DIV_ZERO=0.
- DIVU RS=0x55, RT=0 → no BUSY, DONE next cycle, HI=0x55, LO=0xFF, DIV_ZERO=1; cleared by next START.
- MULTU 15×15, START with OP=MTHI pulsed during BUSY → ignored; HI=0x00, LO=0xE1; then MTHI RS=0xA5 accepted in FIN cycle → HI=0xA5, LO=0xE1, DONE next cycle.
- RESET_N low on 4th BUSY cycle of MULTU 255×255 → abort, no DONE, HI=LO=0; fresh MULTU afterward gives HI=0xFE, LO=0x01.
